// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
//   Round-robin arbiter that locks onto one requester for the length of a
//   packet. It arbitrates in IDLE and grants one cycle later. It then holds
//   the grant in LOCKED until the last beat transfers. After that it returns
//   to IDLE with the next index as top priority.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_req   : per-requester beat valid
//   i_last  : per-requester last-beat flag, qualified by i_req
//   i_ready : downstream accepts the current beat
//   o_sel   : index of the granted requester (downstream mux select)
//   o_gnt   : registered one-hot grant, zero in IDLE
//   o_valid : granted requester has a beat presented downstream
module rr_packet_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [NUM_INPUTS-1:0] i_last,
  input  logic                  i_ready,
  output logic [SEL_WIDTH-1:0]  o_sel,
  output logic [NUM_INPUTS-1:0] o_gnt,
  output logic                  o_valid
);

  if ((NUM_INPUTS < 2) || ((NUM_INPUTS & (NUM_INPUTS - 1)) != 0)) begin : g_bad_num_inputs
    $fatal(1, "rr_packet_arbiter: NUM_INPUTS must be a power of two and >= 2");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [NUM_INPUTS-1:0]   gnt_q, gnt_d;

  logic                    found;
  logic [SEL_WIDTH-1:0]    pick;
  logic [SEL_WIDTH-1:0]    idx;
  logic                    valid;
  logic                    last_xfer;

  assign valid     = (state_q == LOCKED) && i_req[sel_q];
  assign last_xfer = valid && i_ready && i_last[sel_q];

  // Search from ptr upward. The index sum wraps by SEL_WIDTH overflow, which
  // is exact modulo NUM_INPUTS because NUM_INPUTS is a power of two.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      idx = ptr_q + SEL_WIDTH'(i);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = LOCKED;
          sel_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      LOCKED: begin
        if (last_xfer) begin
          state_d = IDLE;
          ptr_d   = sel_q + 1'b1;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_sel   = sel_q;
  assign o_gnt   = gnt_q;
  assign o_valid = valid;

endmodule
